// File: rtl/shot_ctl.sv
// Frame-synchronous shot sequencer for the light-gun path.
// Trigger edge -> consume a round -> black frame(s) -> target frame(s) ->
// hit/miss pulse -> cooldown frames. Owns the HUD ammo count.
// Optional build macro SHOT_STATS_EN adds shots_fired/hits_total counters.
module shot_ctl #(
  parameter int unsigned AMMO_MAX        = 16,
  parameter int unsigned BLACK_FRAMES    = 1,
  parameter int unsigned TARGET_FRAMES   = 1,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       trigger,
  input  logic       sensor,
  input  logic       reload,
  output logic       flash_black,
  output logic       flash_target,
  output logic [4:0] ammo_left,
  output logic       hit,
  output logic       miss,
  output logic       busy
`ifdef SHOT_STATS_EN
  ,
  output logic [7:0] shots_fired,
  output logic [7:0] hits_total
`endif
);

  localparam int unsigned AMMO_W = 5;
  localparam int unsigned CNT_W  = 8;

  localparam logic [AMMO_W-1:0] AMMO_FULL   = AMMO_W'(AMMO_MAX);
  localparam logic [CNT_W-1:0]  BLACK_INIT  = CNT_W'(BLACK_FRAMES - 1);
  localparam logic [CNT_W-1:0]  TARGET_INIT = CNT_W'(TARGET_FRAMES - 1);
  localparam logic [CNT_W-1:0]  COOL_INIT   =
    (COOLDOWN_FRAMES == 0) ? '0 : CNT_W'(COOLDOWN_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_BLACK,
    S_TARGET,
    S_RESULT,
    S_COOLDOWN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_flag_q, hit_flag_d;
  logic               reload_pend_q, reload_pend_d;
  logic [AMMO_W-1:0]  ammo_d;
  logic               hit_d, miss_d;
  logic               reload_apply;

  logic               trig_q;
  logic               vblnk_q;
  logic               sensor_m, sensor_s;
  logic               trig_edge;
  logic               frame_start;

  assign trig_edge   = trigger & ~trig_q;
  assign frame_start = vblnk_q & ~vblnk;

  // Input conditioning: sensor synchroniser, trigger and vblnk edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensor_m <= 1'b0;
      sensor_s <= 1'b0;
      trig_q   <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      sensor_m <= sensor;
      sensor_s <= sensor_m;
      trig_q   <= trigger;
      vblnk_q  <= vblnk;
    end
  end

  // Next-state, counter, ammo and reload bookkeeping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hit_flag_d    = hit_flag_q;
    reload_pend_d = reload_pend_q;
    ammo_d        = ammo_left;
    reload_apply  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Reload takes priority; a simultaneous trigger edge is dropped.
        if (reload) begin
          reload_apply = 1'b1;
        end else if (trig_edge && (ammo_left != '0)) begin
          ammo_d  = ammo_left - AMMO_W'(1);
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (reload) reload_pend_d = 1'b1;
        if (frame_start) begin
          state_d = S_BLACK;
          cnt_d   = BLACK_INIT;
        end
      end
      S_BLACK: begin
        if (reload) reload_pend_d = 1'b1;
        if (frame_start) begin
          if (cnt_q == '0) begin
            state_d    = S_TARGET;
            cnt_d      = TARGET_INIT;
            hit_flag_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_TARGET: begin
        if (reload) reload_pend_d = 1'b1;
        // Only active video counts; blanking cannot register a hit.
        if (!vblnk && sensor_s) hit_flag_d = 1'b1;
        if (frame_start) begin
          if (cnt_q == '0) state_d = S_RESULT;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_RESULT: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_COOLDOWN;
          cnt_d   = COOL_INIT;
        end
        if (reload_pend_q || reload) begin
          reload_apply  = 1'b1;
          reload_pend_d = 1'b0;
        end
      end
      S_COOLDOWN: begin
        if (reload) reload_apply = 1'b1;
        if (frame_start) begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (reload_apply) ammo_d = AMMO_FULL;

    hit_d  = (state_q == S_TARGET) && (state_d == S_RESULT) &&  hit_flag_d;
    miss_d = (state_q == S_TARGET) && (state_d == S_RESULT) && !hit_flag_d;
  end

  // State register and registered next-state output decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hit_flag_q    <= 1'b0;
      reload_pend_q <= 1'b0;
      ammo_left     <= AMMO_FULL;
      flash_black   <= 1'b0;
      flash_target  <= 1'b0;
      busy          <= 1'b0;
      hit           <= 1'b0;
      miss          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hit_flag_q    <= hit_flag_d;
      reload_pend_q <= reload_pend_d;
      ammo_left     <= ammo_d;
      flash_black   <= (state_d == S_BLACK);
      flash_target  <= (state_d == S_TARGET);
      busy          <= (state_d != S_IDLE);
      hit           <= hit_d;
      miss          <= miss_d;
    end
  end

`ifdef SHOT_STATS_EN
  logic       shot_accept;
  logic [7:0] shots_d, hits_d;

  // Saturating shot/hit statistics, cleared whenever a reload takes effect.
  always_comb begin
    shot_accept = (state_q == S_IDLE) && (state_d == S_ARM);
    shots_d     = shots_fired;
    hits_d      = hits_total;
    if (reload_apply) begin
      shots_d = '0;
      hits_d  = '0;
    end else begin
      if (shot_accept && (shots_fired != 8'hFF)) shots_d = shots_fired + 8'd1;
      if (hit_d && (hits_total != 8'hFF))        hits_d  = hits_total + 8'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shots_fired <= '0;
      hits_total  <= '0;
    end else begin
      shots_fired <= shots_d;
      hits_total  <= hits_d;
    end
  end
`endif

endmodule

// File: tb/tb_shot_ctl.sv
// Self-checking bench for shot_ctl with a short synthetic frame timing.
// hit/miss pulses are checked against a scoreboard queue filled per shot.
module tb_shot_ctl;

  localparam int FRAME    = 40;
  localparam int VB_START = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vblnk = 1'b0;
  logic       trigger;
  logic       sensor;
  logic       reload;
  logic       flash_black;
  logic       flash_target;
  logic [4:0] ammo_left;
  logic       hit;
  logic       miss;
  logic       busy;
`ifdef SHOT_STATS_EN
  logic [7:0] shots_fired;
  logic [7:0] hits_total;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int pix    = 0;
  int exp_ammo;
  logic [1:0] sb[$];

  shot_ctl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vblnk        (vblnk),
    .trigger      (trigger),
    .sensor       (sensor),
    .reload       (reload),
    .flash_black  (flash_black),
    .flash_target (flash_target),
    .ammo_left    (ammo_left),
    .hit          (hit),
    .miss         (miss),
    .busy         (busy)
`ifdef SHOT_STATS_EN
    ,
    .shots_fired  (shots_fired),
    .hits_total   (hits_total)
`endif
  );

  always #5 clk = ~clk;

  // Free-running frame timing: vblnk high for the last lines of each frame.
  always @(posedge clk) begin
    #1;
    pix   = (pix == FRAME - 1) ? 0 : pix + 1;
    vblnk = (pix >= VB_START);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every hit/miss pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (hit || miss) begin
      if (sb.size() == 0) chk("sb_unexpected", {hit, miss}, 2'b00);
      else                chk("sb_result", {hit, miss}, sb.pop_front());
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return busy;
      1:       return flash_black;
      default: return flash_target;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic val, input int limit);
    int n = 0;
    while (sig(sel) !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk(tag, sig(sel), val);
  endtask

  task automatic pulse_sensor(input int start);
    while (pix != start - 1) @(negedge clk);
    @(posedge clk); #1 sensor = 1'b1;
    repeat (3) @(posedge clk);
    #1 sensor = 1'b0;
  endtask

  task automatic fire();
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  // mode: 0 no light, 1 light mid-line, 2 light during blanking only.
  task automatic do_shot(input int mode, input bit exp_hit, input bit spam);
    wait_for("idle_pre", 0, 1'b0, 2000);
    exp_ammo--;
    sb.push_back(exp_hit ? 2'b10 : 2'b01);
    fire();
    @(negedge clk);
    chk("ammo_dec", ammo_left, exp_ammo);
    wait_for("tgt_on", 2, 1'b1, 200);
    if (mode == 1) pulse_sensor(14);
    else if (mode == 2) pulse_sensor(31);
    if (spam) begin
      fire();
      wait_for("tgt_off", 2, 1'b0, 200);
      repeat (20) @(posedge clk);
      #1 trigger = 1'b1;
      wait_for("idle_held", 0, 1'b0, 1000);
      repeat (60) @(negedge clk);
      chk("held_no_fire", busy, 1'b0);
      chk("held_ammo", ammo_left, exp_ammo);
      trigger = 1'b0;
    end
    wait_for("idle_post", 0, 1'b0, 1000);
    chk("ammo_idle", ammo_left, exp_ammo);
  endtask

  initial begin
    int n;
    int act;
    rst_n   = 1'b0;
    trigger = 1'b0;
    sensor  = 1'b0;
    reload  = 1'b0;
    exp_ammo = 16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ammo", ammo_left, 5'd16);
    chk("rst_busy", busy, 1'b0);
    chk("rst_black", flash_black, 1'b0);
    chk("rst_target", flash_target, 1'b0);
    chk("rst_hitmiss", {hit, miss}, 2'b00);
`ifdef SHOT_STATS_EN
    chk("rst_stats", {shots_fired, hits_total}, 16'h0000);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Shot 1: detailed frame-level timing, no light -> miss.
    exp_ammo = 15;
    sb.push_back(2'b01);
    fire();
    @(negedge clk);
    chk("t1_ammo", ammo_left, 5'd15);
    chk("t1_busy", busy, 1'b1);
    chk("t1_arm_noflash", flash_black, 1'b0);
    wait_for("t1_black_on", 1, 1'b1, 200);
    n = 0;
    while (flash_black === 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("t1_black_len", n, FRAME);
    chk("t1_target_follows", flash_target, 1'b1);
    n = 0;
    while (flash_target === 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("t1_target_len", n, FRAME);
    chk("t1_result_busy", busy, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("t1_cooldown_len", n, 8 * FRAME);

    do_shot(1, 1'b1, 1'b0);   // 14: light mid-line -> hit
    do_shot(2, 1'b0, 1'b0);   // 13: light only in blanking -> miss
    do_shot(0, 1'b0, 1'b1);   // 12: trigger spam during target/cooldown
    do_shot(0, 1'b0, 1'b0);   // 11

    // Reload during BLACK is deferred to cooldown entry.
    exp_ammo = 10;
    sb.push_back(2'b01);
    fire();
    wait_for("rl_black_on", 1, 1'b1, 200);
    @(posedge clk); #1 reload = 1'b1;
    @(posedge clk); #1 reload = 1'b0;
    @(negedge clk);
    chk("rl_ammo_black", ammo_left, 5'd10);
    wait_for("rl_tgt_on", 2, 1'b1, 200);
    chk("rl_ammo_target", ammo_left, 5'd10);
    wait_for("rl_tgt_off", 2, 1'b0, 200);
    chk("rl_ammo_result", ammo_left, 5'd10);
    @(negedge clk);
    chk("rl_ammo_cool", ammo_left, 5'd16);
    exp_ammo = 16;
    wait_for("rl_idle", 0, 1'b0, 1000);

    // Reload and trigger edge in the same IDLE cycle: reload wins.
    do_shot(0, 1'b0, 1'b0);   // 15
    @(posedge clk); #1 trigger = 1'b1; reload = 1'b1;
    @(posedge clk); #1 trigger = 1'b0; reload = 1'b0;
    @(negedge clk);
    chk("rt_ammo", ammo_left, 5'd16);
    chk("rt_busy", busy, 1'b0);
    act = 0;
    repeat (2 * FRAME) begin @(negedge clk); act += int'(busy | flash_black | flash_target); end
    chk("rt_no_shot", act, 0);
    exp_ammo = 16;

    // Empty the magazine, then a 17th trigger must be ignored.
    for (int i = 0; i < 16; i++) do_shot(0, 1'b0, 1'b0);
    chk("empty_ammo", ammo_left, 5'd0);
    fire();
    act = 0;
    repeat (2 * FRAME) begin @(negedge clk); act += int'(busy | flash_black | flash_target); end
    chk("empty_no_shot", act, 0);
    chk("empty_ammo_after", ammo_left, 5'd0);
    @(posedge clk); #1 reload = 1'b1;
    @(posedge clk); #1 reload = 1'b0;
    @(negedge clk);
    chk("idle_reload", ammo_left, 5'd16);
    exp_ammo = 16;

    // Three shots, two hits.
    do_shot(1, 1'b1, 1'b0);
    do_shot(1, 1'b1, 1'b0);
    do_shot(0, 1'b0, 1'b0);
`ifdef SHOT_STATS_EN
    chk("stats_shots", shots_fired, 8'd3);
    chk("stats_hits", hits_total, 8'd2);
`endif

    // Reset during TARGET aborts the shot without a result.
    fire();
    wait_for("rst_tgt_on", 2, 1'b1, 200);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ammo", ammo_left, 5'd16);
    chk("mid_rst_outs", {flash_black, flash_target, hit, miss, busy}, 5'b00000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    act = 0;
    repeat (10 * FRAME) begin
      @(negedge clk);
      act += int'(busy | flash_black | flash_target | hit | miss);
    end
    chk("mid_rst_quiet", act, 0);
    chk("mid_rst_ammo_after", ammo_left, 5'd16);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_ctl.md
Name: shot_ctl

Overview:
- Frame-synchronous shot sequencer for the light-gun path.
- On a trigger it consumes one round of ammo and commands the draw pipeline to render one or more black frames, then one or more target frames.
- During target-frame active video it samples the photodiode and reports hit or miss.
- Sits between the input conditioning, the VGA timing generator (consumes vblnk) and the background/duck draw stages (drives flash controls). Owns the ammo count shown by the HUD.

Parameters:
- AMMO_MAX, 16 (vga_pkg::AMMO_QUANTITY): rounds after reset/reload; legal 1..16.
- BLACK_FRAMES, 1: black frames per shot; legal >=1.
- TARGET_FRAMES, 1: target frames per shot; legal >=1.
- COOLDOWN_FRAMES, 8: frames after result before next trigger is accepted; legal >=0.

Ports:
- clk  in  1  65 MHz pixel clock.
- rst_n  in  1  asynchronous reset, active low.
- vblnk  in  1  vertical blank from timing generator; same clock domain.
- trigger  in  1  debounced gun trigger, level.
- sensor  in  1  photodiode, asynchronous; synchronised internally.
- reload  in  1  reload request, single-cycle pulse.
- flash_black  out  1  draw full-screen black this frame.
- flash_target  out  1  draw black screen with white target boxes this frame.
- ammo_left  out  5  remaining rounds, 0..AMMO_MAX.
- hit  out  1  single-cycle pulse: shot hit.
- miss  out  1  single-cycle pulse: shot missed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, except ammo_left = AMMO_MAX. State IDLE, all counters 0.
- Reset mid-shot aborts the shot. No hit/miss is issued and ammo is restored to AMMO_MAX.
- sensor passes through a 2-flop synchroniser (sensor_s). trigger is registered and edge-detected; only a rising edge fires.
- frame_start: single-cycle pulse on the vblnk 1->0 transition, i.e. the first active line.
- FSM:
  - IDLE: trigger edge and ammo_left>0 -> ammo_left-1 on the same clock, go ARM. Trigger edge with ammo_left==0 is ignored.
  - ARM: wait for frame_start -> BLACK, cnt=BLACK_FRAMES-1.
  - BLACK: flash_black=1. On frame_start: cnt==0 -> TARGET, cnt=TARGET_FRAMES-1, clear hit_flag; else cnt-1.
  - TARGET: flash_target=1. Any cycle with vblnk==0 and sensor_s==1 sets hit_flag (sticky). On frame_start: cnt==0 -> RESULT; else cnt-1.
  - RESULT: one cycle. hit=hit_flag, miss=!hit_flag. Then COOLDOWN_FRAMES==0 -> IDLE; else COOLDOWN, cnt=COOLDOWN_FRAMES-1.
  - COOLDOWN: on frame_start: cnt==0 -> IDLE; else cnt-1.
- Flash outputs and busy are registered decodes of the next state. They are valid on the clock the state is entered and are stable across whole frames. A flash frame always begins at frame_start, never mid-frame.
- Sensor samples during vblnk==1 are ignored, so blanking cannot cause a false hit.
- Trigger edges outside IDLE are dropped, not queued.
- Reload:
  - In IDLE or COOLDOWN: ammo_left=AMMO_MAX on the next clock.
  - In ARM, BLACK, TARGET or RESULT: latched in reload_pend and applied on entry to COOLDOWN/IDLE.
  - Reload and trigger edge on the same IDLE cycle: reload wins and the trigger is dropped.
- ammo_left never underflows below 0 and never exceeds AMMO_MAX.
- Frame counters are 8 bits wide.
- hit and miss are mutually exclusive and each is exactly one cycle per accepted shot.

Optional Feature:
- Macro SHOT_STATS_EN.
- When defined, adds outputs shots_fired[7:0] and hits_total[7:0], both reset to 0:
  - shots_fired increments on each accepted trigger.
  - hits_total increments on each hit pulse.
  - Both saturate at 255 and are cleared by reload.
- Without the macro these ports and registers do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset, then trigger edge in IDLE with ammo 16 -> ammo_left=15 next clock; flash_black for exactly 1 full frame starting at the next frame_start; then flash_target for 1 frame; then miss pulse 1 cycle (sensor held 0); busy drops after 8 cooldown frames.
- Sensor pulsed high for 3 cycles mid-line in the target frame -> hit=1 for exactly 1 cycle, miss stays 0. Same pulse during vblnk only -> miss.
- 16 completed shots, then a 17th trigger -> ammo_left=0; the 17th is ignored, busy stays 0 and there is no flash.
- Reload pulse during BLACK with ammo 10 -> ammo_left stays 10 until COOLDOWN entry, then 16. Reload and trigger on the same IDLE cycle -> ammo_left=16, busy=0.
- Trigger edges during TARGET and COOLDOWN -> no ammo change and no extra shot. Trigger held high across IDLE return -> no new shot without a new edge.
- rst_n asserted in TARGET -> all outputs 0 immediately, ammo_left=16, no hit/miss after release. With SHOT_STATS_EN: 3 shots with 2 hits -> shots_fired=3, hits_total=2.
